// File: rtl/seg_display_ctrl_if.sv
// Register write and software-scan capture port of the seven-segment controller.
interface seg_display_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SEG_W      = 8
);
  localparam int unsigned ADDR_W = $clog2(NUM_DIGITS + 2);

  logic                  wr_en_i;
  logic [ADDR_W-1:0]     wr_addr_i;
  logic [SEG_W-1:0]      wr_data_i;
  logic                  cap_en_i;
  logic [NUM_DIGITS-1:0] cap_sel_ni;
  logic [SEG_W-1:0]      cap_data_i;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, cap_en_i, cap_sel_ni, cap_data_i
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, cap_en_i, cap_sel_ni, cap_data_i
  );
endinterface

// File: rtl/seg_display_ctrl.sv
// N-digit seven-segment controller: segment register file with hex decode,
// per-digit blink, static outputs and a multiplexed scan bus.
module seg_display_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SEG_W      = 8,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLINK_DIV  = 12500000,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  seg_display_ctrl_if.slave           bus,
  output logic [NUM_DIGITS*SEG_W-1:0] seg_o,
  output logic [SEG_W-1:0]            scan_seg_o,
  output logic [NUM_DIGITS-1:0]       scan_an_o
);
  localparam int unsigned ADDR_W  = $clog2(NUM_DIGITS + 2);
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic        INV     = (ACTIVE_LOW != 0);

  logic [SEG_W-1:0]            digit_q [NUM_DIGITS];
  logic [SEG_W-1:0]            digit_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]       dec_q, dec_d, blink_q, blink_d;
  logic [SCAN_W-1:0]           scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]            scan_idx_q, scan_idx_d;
  logic [BLINK_W-1:0]          blink_cnt_q, blink_cnt_d;
  logic                        phase_q, phase_d;
  logic [NUM_DIGITS*SEG_W-1:0] seg_q, seg_d;
  logic [SEG_W-1:0]            scan_seg_q, scan_seg_d;
  logic [NUM_DIGITS-1:0]       scan_an_q, scan_an_d;
  logic [SEG_W-1:0]            disp [NUM_DIGITS];
  int unsigned                 cap_zeros;
  logic [IDX_W-1:0]            cap_j;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Displayed value per digit: optional decode of the low nibble, then blink blanking.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      disp[i] = digit_q[i];
      if (dec_q[i]) disp[i][6:0] = hex7(digit_q[i][3:0]);
      if (blink_q[i] && phase_q) disp[i] = '0;
    end
  end

  // Register file update; the direct write is applied last so it wins a collision.
  always_comb begin
    digit_d   = digit_q;
    dec_d     = dec_q;
    blink_d   = blink_q;
    cap_zeros = 0;
    cap_j     = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if (!bus.cap_sel_ni[j]) begin
        cap_zeros = cap_zeros + 1;
        cap_j     = IDX_W'(j);
      end
    end
    if (bus.cap_en_i && cap_zeros == 1)
      digit_d[IDX_W'(NUM_DIGITS - 1) - cap_j] = bus.cap_data_i;
    if (bus.wr_en_i) begin
      if (bus.wr_addr_i < ADDR_W'(NUM_DIGITS))
        digit_d[bus.wr_addr_i[IDX_W-1:0]] = bus.wr_data_i;
      else if (bus.wr_addr_i == ADDR_W'(NUM_DIGITS))
        dec_d = bus.wr_data_i[NUM_DIGITS-1:0];
      else if (bus.wr_addr_i == ADDR_W'(NUM_DIGITS + 1))
        blink_d = bus.wr_data_i[NUM_DIGITS-1:0];
    end
  end

  // Free-running scan and blink timebases, plus the output registers.
  always_comb begin
    scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
    scan_idx_d  = scan_idx_q;
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    phase_d     = phase_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
    end
    if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
    for (int i = 0; i < NUM_DIGITS; i++)
      seg_d[i*SEG_W +: SEG_W] = disp[i] ^ {SEG_W{INV}};
    scan_seg_d = disp[scan_idx_q] ^ {SEG_W{INV}};
    scan_an_d  = (NUM_DIGITS'(1) << scan_idx_q) ^ {NUM_DIGITS{INV}};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
      dec_q       <= '0;
      blink_q     <= '0;
      scan_cnt_q  <= '0;
      scan_idx_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      seg_q       <= {(NUM_DIGITS*SEG_W){INV}};
      scan_seg_q  <= {SEG_W{INV}};
      scan_an_q   <= NUM_DIGITS'(1) ^ {NUM_DIGITS{INV}};
    end else begin
      digit_q     <= digit_d;
      dec_q       <= dec_d;
      blink_q     <= blink_d;
      scan_cnt_q  <= scan_cnt_d;
      scan_idx_q  <= scan_idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      seg_q       <= seg_d;
      scan_seg_q  <= scan_seg_d;
      scan_an_q   <= scan_an_d;
    end
  end

  assign seg_o      = seg_q;
  assign scan_seg_o = scan_seg_q;
  assign scan_an_o  = scan_an_q;
endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Parametrised seven-segment display controller for N digits.
- Holds a persistent per-digit segment register file, loaded from a direct write port or by capturing a software-scanned, one-hot-low digit select driven by the core.
- Adds optional hex-nibble decode, per-digit blink, and a multiplexed scan output alongside the static per-digit outputs.
- Sits between MonocicloCore I/O ports and the board HEX pins.

Parameters:
- NUM_DIGITS, 4, number of digits (2..8).
- SEG_W, 8, segment bits per digit; bit 7 = decimal point, bits 6:0 = g..a.
- SCAN_DIV, 50000, clk cycles per scan step.
- BLINK_DIV, 12500000, clk cycles per blink half-period.
- ACTIVE_LOW, 1, 1 = segment and anode outputs inverted (0 = lit/selected).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- wr_en_i  in  1  register write strobe.
- wr_addr_i  in  ADDR_W=$clog2(NUM_DIGITS+2)  0..N-1 = digit, N = decode mask, N+1 = blink mask.
- wr_data_i  in  SEG_W  write data; masks use the low NUM_DIGITS bits.
- cap_en_i  in  1  capture strobe for software-scan data.
- cap_sel_ni  in  NUM_DIGITS  one-hot-low digit select from the core.
- cap_data_i  in  SEG_W  active-high segment data for the captured digit.
- seg_o  out  NUM_DIGITS*SEG_W  static outputs; digit i at [i*SEG_W +: SEG_W].
- scan_seg_o  out  SEG_W  multiplexed segment bus.
- scan_an_o  out  NUM_DIGITS  one-hot digit enable for the scan bus.

Behaviour:
- Internal polarity:
  - Register contents are active-high (1 = lit).
  - When ACTIVE_LOW=1, seg_o, scan_seg_o and scan_an_o are bitwise inverted at the output register.
  - Blank = all segments off.
- Reset (rst_i=1 at a clk edge), values effective after that edge:
  - All digit registers, decode mask, blink mask, scan counter, scan index, blink counter and blink phase = 0.
  - seg_o and scan_seg_o = all off (all 1s when ACTIVE_LOW).
  - scan_an_o = digit 0 selected.
  - Reset mid-operation discards everything; nothing is retained.
- Direct write:
  - wr_en_i=1 at edge k updates the addressed register at edge k.
  - Addresses above N+1 are ignored.
- Capture:
  - Active when cap_en_i=1 and cap_sel_ni has exactly one 0 bit, at bit j.
  - Writes cap_data_i to digit NUM_DIGITS-1-j. For N=4: 11110111 → digit 0, 11111110 → digit 3.
  - All-ones, or more than one zero, → no write.
- Simultaneous events: wr_en_i and capture to the same digit in the same cycle → wr_en_i wins. Different digits → both write.
- Decode, when decode mask bit i = 1:
  - wr_data[3:0] maps through the standard 0-F table (0 = 0x3F, 1 = 0x06, 8 = 0x7F, F = 0x71, active-high g..a).
  - Bit 7 passes through as dp; bits 6:4 are ignored.
  - Decode mask bit i = 0 → raw segment bits.
- Blink:
  - Blink counter runs 0..BLINK_DIV-1; phase toggles on wrap.
  - While phase=1, digits with blink mask bit set are blanked on both the static and scan paths.
  - Register contents are unaffected.
- Scan:
  - Scan counter runs 0..SCAN_DIV-1.
  - On wrap, the scan index advances and wraps from N-1 to 0.
  - scan_an_o enables only the indexed digit; scan_seg_o carries that digit's post-decode, post-blink value.
  - scan_seg_o and scan_an_o change on the same edge (no ghost cycle).
- Latency:
  - All outputs are registered.
  - A write at edge k appears on seg_o after edge k+1.
  - If the digit is currently scanned, it appears on scan_seg_o after edge k+1.

Test Plan:
Benches use NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=8, ACTIVE_LOW=1.
1. Reset: hold rst_i 2 cycles with random inputs → seg_o=0xFFFFFFFF, scan_an_o=4'b1110, masks 0.
2. Capture with cap_en_i=1:
   - sel 8'b11110111, data 0x06 → digit0 = 0x06, seg_o[7:0]=0xF9 one cycle later.
   - sel 8'b11110011 → no change.
   - sel 8'hFF → no change.
3. Decode: write addr 4 = 0x02, then digit1 = 0x8A → seg_o[15:8] = ~(0x80|0x77) = 0x08.
4. Collision: wr_en digit2=0x3F together with capture sel 11111101 data 0x06 → digit2 = 0x3F.
5. Scan: digits 0x01/0x02/0x04/0x08 → scan_an_o steps 1110,1101,1011,0111,1110 every 4 cycles; scan_seg_o matches the inverted digit each step.
6. Blink and reset:
   - Blink mask 0x1: seg_o[7:0] alternates value/0xFF every 8 cycles; other digits steady.
   - Assert rst_i mid-phase → blank, phase 0.
